// File: rtl/btn_pkg.sv
// Shared defaults and helpers for the push-button debouncer.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
package btn_pkg;

  localparam int DB_CYCLES_10MS   = 250000;
  localparam int REP_DELAY_500MS  = 12500000;
  localparam int REP_PERIOD_100MS = 2500000;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop sync, debounce counter, strobes.
// Auto-repeat on held buttons when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_10MS,
  parameter int REP_DELAY  = REP_DELAY_500MS,
  parameter int REP_PERIOD = REP_PERIOD_100MS
) (
  input  logic clk_25mhz,
  input  logic rst,
  input  logic btn,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release
);

  localparam int CW = cnt_w(DB_CYCLES);

  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt;
  logic          accept;

  assign s      = sync[1];
  assign accept = (s != btn_state) && (cnt == CW'(DB_CYCLES - 1));

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = cnt_w(max2(REP_DELAY, REP_PERIOD));

  logic [RW-1:0] rcnt;
  logic          rarm;
  logic [RW-1:0] rlim;

  // First repeat waits the long delay, later ones the short period.
  assign rlim = rarm ? RW'(REP_PERIOD - 1) : RW'(REP_DELAY - 1);
`endif

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      sync        <= '0;
      cnt         <= '0;
      btn_state   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt        <= '0;
      rarm        <= 1'b0;
`endif
    end else begin
      sync        <= {sync[0], btn};
      btn_press   <= 1'b0;
      btn_release <= 1'b0;

      if (s == btn_state) begin
        cnt <= '0;
      end else if (accept) begin
        cnt         <= '0;
        btn_state   <= s;
        btn_press   <= s;
        btn_release <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end

`ifdef BTN_AUTOREPEAT_EN
      // accept while held is a release: no repeat in that cycle.
      if (!btn_state || accept) begin
        rcnt <= '0;
        rarm <= 1'b0;
      end else if (rcnt == rlim) begin
        rcnt      <= '0;
        rarm      <= 1'b1;
        btn_press <= 1'b1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
`endif
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounces N_BTN raw push-buttons into levels and press/release strobes.
// Define BTN_AUTOREPEAT_EN to add auto-repeat presses while held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN      = 7,
  parameter int DB_CYCLES  = DB_CYCLES_10MS,
  parameter int REP_DELAY  = REP_DELAY_500MS,
  parameter int REP_PERIOD = REP_PERIOD_100MS
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD)
    ) u_chan (
      .clk_25mhz   (clk_25mhz),
      .rst         (rst),
      .btn         (btn[i]),
      .btn_state   (btn_state[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random pins,
// checked every cycle against a timestamp-based reference model.
module tb_btn_debounce;

  localparam int N  = 7;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic         clk_25mhz = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] btn_state;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  btn_debounce #(
    .N_BTN      (N),
    .DB_CYCLES  (DB),
    .REP_DELAY  (RD),
    .REP_PERIOD (RP)
  ) dut (
    .clk_25mhz   (clk_25mhz),
    .rst         (rst),
    .btn         (btn),
    .btn_state   (btn_state),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int total = 0;
  int bad   = 0;

  // Reference model: a change is accepted once the synchronised
  // pin has disagreed with the level for DB edges in a row.
  int           t = 0;
  bit           m_s1   [N];
  bit           m_s2   [N];
  bit           m_state[N];
  int           m_since[N];
  int           m_tp   [N];
  logic [N-1:0] e_state = '0;
  logic [N-1:0] e_press = '0;
  logic [N-1:0] e_rel   = '0;
  int           p_cnt  [N];
  int           r_cnt  [N];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    t++;
    for (int c = 0; c < N; c++) begin
      bit s;
      bit acc;
      if (rst) begin
        m_s1[c]    = 1'b0;
        m_s2[c]    = 1'b0;
        m_state[c] = 1'b0;
        m_since[c] = t;
        e_press[c] = 1'b0;
        e_rel[c]   = 1'b0;
      end else begin
        s          = m_s2[c];
        acc        = 1'b0;
        e_press[c] = 1'b0;
        e_rel[c]   = 1'b0;
        if (s == m_state[c]) m_since[c] = t;
        else if (t - m_since[c] == DB) begin
          acc        = 1'b1;
          m_since[c] = t;
        end
`ifdef BTN_AUTOREPEAT_EN
        if (m_state[c] && !acc && (t - m_tp[c]) >= RD &&
            ((t - m_tp[c] - RD) % RP) == 0)
          e_press[c] = 1'b1;
`endif
        if (acc) begin
          m_state[c] = s;
          if (s) begin
            e_press[c] = 1'b1;
            m_tp[c]    = t;
          end else begin
            e_rel[c] = 1'b1;
          end
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = btn[c];
      end
      e_state[c] = m_state[c];
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    model_edge();
    @(negedge clk_25mhz);
    chk("state", 32'(btn_state), 32'(e_state));
    chk("press", 32'(btn_press), 32'(e_press));
    chk("release", 32'(btn_release), 32'(e_rel));
    for (int c = 0; c < N; c++) begin
      p_cnt[c] += int'(btn_press[c]);
      r_cnt[c] += int'(btn_release[c]);
    end
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < N; c++) begin
      p_cnt[c] = 0;
      r_cnt[c] = 0;
    end
  endtask

  initial begin
    int te;
    int n;
    int t0;
    int trel;
    int sum;
    int pq[$];
    int eq[$];

    // 1: reset, idle pins, no strobes
    rst = 1'b1;
    btn = '0;
    repeat (3) tick();
    chk("rst_state", 32'(btn_state), 32'd0);
    rst = 1'b0;
    clr_cnt();
    repeat (100) tick();
    sum = 0;
    for (int c = 0; c < N; c++) sum += p_cnt[c] + r_cnt[c];
    chk("idle_strobes", 32'(sum), 32'd0);

    // 2: clean press on btn[1]
    btn[1] = 1'b1;
    te = t;
    n = 0;
    while (!btn_press[1] && n < 20) begin tick(); n++; end
    chk("t2_latency", 32'(t - te), 32'd6);
    chk("t2_state", 32'(btn_state[1]), 32'd1);
    tick();
    chk("t2_one_cycle", 32'(btn_press[1]), 32'd0);
    btn[1] = 1'b0;
    repeat (10) tick();

    // 3: bounce on btn[1], then settle high
    clr_cnt();
    for (int i = 0; i < 20; i++) begin
      btn[1] = ~btn[1];
      tick();
      tick();
    end
    chk("t3_bounce", 32'(p_cnt[1] + r_cnt[1]), 32'd0);
    btn[1] = 1'b1;
    te = t;
    n = 0;
    while (!btn_press[1] && n < 20) begin tick(); n++; end
    chk("t3_latency", 32'(t - te), 32'd6);
    repeat (8) tick();
    chk("t3_single", 32'(p_cnt[1]), 32'd1);
    btn[1] = 1'b0;
    repeat (10) tick();

    // 4: simultaneous channels 0 and 6
    btn[0] = 1'b1;
    btn[6] = 1'b1;
    n = 0;
    while (!btn_press[0] && n < 20) begin tick(); n++; end
    chk("t4_press6", 32'(btn_press[6]), 32'd1);
    btn[0] = 1'b0;
    btn[6] = 1'b0;
    te = t;
    n = 0;
    while (!btn_release[0] && n < 20) begin tick(); n++; end
    chk("t4_rel_latency", 32'(t - te), 32'd6);
    chk("t4_release6", 32'(btn_release[6]), 32'd1);
    repeat (10) tick();

    // 5: reset mid-count with btn[2] held
    btn[2] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("t5_rst_out",
        32'({btn_state, btn_press, btn_release}), 32'd0);
    rst = 1'b0;
    te = t;
    n = 0;
    while (!btn_press[2] && n < 20) begin tick(); n++; end
    chk("t5_latency", 32'(t - te), 32'd6);
    btn[2] = 1'b0;
    repeat (10) tick();

    // 6: hold btn[3]; release lands on a would-be repeat slot
    btn[3] = 1'b1;
    n = 0;
    while (!btn_press[3] && n < 20) begin tick(); n++; end
    chk("t6_first", 32'(btn_press[3]), 32'd1);
    t0 = t;
    pq.push_back(0);
    trel = -1;
    for (int i = 0; i < 38; i++) begin
      tick();
      if (btn_press[3]) pq.push_back(t - t0);
    end
    btn[3] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (btn_press[3]) pq.push_back(t - t0);
      if (btn_release[3]) trel = t - t0;
    end
`ifdef BTN_AUTOREPEAT_EN
    eq = '{0, 20, 28, 36};
`else
    eq = '{0};
`endif
    chk("t6_npress", 32'(pq.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++)
      if (i < pq.size()) chk("t6_press_t", 32'(pq[i]), 32'(eq[i]));
    chk("t6_release_t", 32'(trel), 32'd44);

    // Random pins, fast then slow, with occasional resets
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        for (int c = 0; c < N; c++)
          if ($urandom_range(ph ? 39 : 5) == 0) btn[c] = ~btn[c];
        rst = ($urandom_range(299) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
